// File: rtl/muldiv_if.sv
// Issue, ID-hazard and writeback signals shared between the core and muldiv_unit.
interface muldiv_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              issue_valid;
    logic [2:0]        issue_op;
    logic [XLEN-1:0]   issue_a;
    logic [XLEN-1:0]   issue_b;
    logic [REG_AW-1:0] issue_rd;
    logic              issue_flush;
    logic              issue_ready;
    logic              id_rs1_re;
    logic [REG_AW-1:0] id_rs1_addr;
    logic              id_rs2_re;
    logic [REG_AW-1:0] id_rs2_addr;
    logic              id_rd_we;
    logic [REG_AW-1:0] id_rd_addr;
    logic              stall_req;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;

    modport master (
        output issue_valid, issue_op, issue_a, issue_b, issue_rd, issue_flush,
        output id_rs1_re, id_rs1_addr, id_rs2_re, id_rs2_addr, id_rd_we, id_rd_addr,
        input  issue_ready, stall_req, wb_valid, wb_addr, wb_data
    );
    modport slave (
        input  issue_valid, issue_op, issue_a, issue_b, issue_rd, issue_flush,
        input  id_rs1_re, id_rs1_addr, id_rs2_re, id_rs2_addr, id_rd_we, id_rd_addr,
        output issue_ready, stall_req, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply (pipelined) and divide (iterative, 1 bit/cycle) unit with a
// shared registered writeback port and an in-flight scoreboard driving stall_req.
module muldiv_unit #(
    parameter int XLEN        = 32,
    parameter int MULT_STAGES = 3,
    parameter int REG_AW      = 5
) (
    input logic   clk,
    input logic   rst,
    muldiv_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2;
    localparam int CW   = $clog2(XLEN + 1);
    localparam int NREG = 1 << REG_AW;

    logic [1:0] st;
    logic       is_div, acc, acc_mul, acc_div;

    assign is_div          = bus.issue_op[2];
    assign bus.issue_ready = !(is_div && st != S_IDLE);
    assign acc             = bus.issue_valid & ~bus.issue_flush & bus.issue_ready;
    assign acc_mul         = acc & ~is_div & (bus.issue_rd != '0);
    assign acc_div         = acc & is_div;

    // Product computed at issue; only the result travels down the pipe.
    logic                     a_s, b_s;
    logic signed [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN-1:0]          mres;

    assign a_s  = (bus.issue_op == 3'd1) || (bus.issue_op == 3'd2);
    assign b_s  = (bus.issue_op == 3'd1);
    assign ma   = {{XLEN{a_s & bus.issue_a[XLEN-1]}}, bus.issue_a};
    assign mb   = {{XLEN{b_s & bus.issue_b[XLEN-1]}}, bus.issue_b};
    assign prod = ma * mb;
    assign mres = (bus.issue_op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    logic              mfin_vld;
    logic [REG_AW-1:0] mfin_rd;
    logic [XLEN-1:0]   mfin_data;
    logic [NREG-1:0]   pipe_busy;

    // The wb register is the last of the MULT_STAGES stages.
    generate
        if (MULT_STAGES == 1) begin : g_comb
            assign mfin_vld  = acc_mul;
            assign mfin_rd   = bus.issue_rd;
            assign mfin_data = mres;
            assign pipe_busy = '0;
        end else begin : g_pipe
            localparam int PS = MULT_STAGES - 1;
            logic [PS-1:0]             vld_pipe;
            logic [PS-1:0][REG_AW-1:0] rd_pipe;
            logic [PS-1:0][XLEN-1:0]   dat_pipe;

            always_ff @(posedge clk) begin
                if (rst) vld_pipe <= '0;
                else begin
                    vld_pipe[0] <= acc_mul;
                    for (int i = 1; i < PS; i++) vld_pipe[i] <= vld_pipe[i-1];
                end
            end

            always_ff @(posedge clk) begin
                rd_pipe[0]  <= bus.issue_rd;
                dat_pipe[0] <= mres;
                for (int i = 1; i < PS; i++) begin
                    rd_pipe[i]  <= rd_pipe[i-1];
                    dat_pipe[i] <= dat_pipe[i-1];
                end
            end

            always_comb begin
                pipe_busy = '0;
                for (int i = 0; i < PS; i++)
                    if (vld_pipe[i]) pipe_busy[rd_pipe[i]] = 1'b1;
            end

            assign mfin_vld  = vld_pipe[PS-1];
            assign mfin_rd   = rd_pipe[PS-1];
            assign mfin_data = dat_pipe[PS-1];
        end
    endgenerate

    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   dq, dr, db, dres;
    logic [REG_AW-1:0] drd;
    logic              neg_q, neg_r, is_rem;
    logic [XLEN:0]     shl, diff;
    logic [XLEN-1:0]   it_r, it_q, fin_div, div_out;
    logic              a_neg, b_neg, ovf, div_rdy, div_retire, div_wb;

    assign a_neg = ~bus.issue_op[0] & bus.issue_a[XLEN-1];
    assign b_neg = ~bus.issue_op[0] & bus.issue_b[XLEN-1];
    assign ovf   = ~bus.issue_op[0] && bus.issue_a == {1'b1, {(XLEN-1){1'b0}}}
                   && bus.issue_b == '1;

    assign shl     = {dr, dq[XLEN-1]};
    assign diff    = shl - {1'b0, db};
    assign it_r    = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
    assign it_q    = {dq[XLEN-2:0], ~diff[XLEN]};
    assign fin_div = is_rem ? (neg_r ? -it_r : it_r) : (neg_q ? -it_q : it_q);

    // The final iteration feeds the wb mux directly; DONE only holds results
    // that lost arbitration or came from the special cases.
    assign div_rdy    = (st == S_CALC && cnt == CW'(1)) || st == S_DONE;
    assign div_out    = (st == S_DONE) ? dres : fin_div;
    assign div_retire = div_rdy & (~mfin_vld | (drd == '0));
    assign div_wb     = div_rdy & ~mfin_vld & (drd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= S_IDLE;
            cnt <= '0;
        end else begin
            case (st)
                S_IDLE: if (acc_div) begin
                    drd <= bus.issue_rd;
                    if (bus.issue_b == '0) begin
                        dres <= bus.issue_op[1] ? bus.issue_a : '1;
                        st   <= S_DONE;
                    end else if (ovf) begin
                        dres <= bus.issue_op[1] ? '0 : bus.issue_a;
                        st   <= S_DONE;
                    end else begin
                        dq     <= a_neg ? -bus.issue_a : bus.issue_a;
                        db     <= b_neg ? -bus.issue_b : bus.issue_b;
                        dr     <= '0;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        is_rem <= bus.issue_op[1];
                        cnt    <= CW'(XLEN);
                        st     <= S_CALC;
                    end
                end
                S_CALC: begin
                    dr  <= it_r;
                    dq  <= it_q;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        dres <= fin_div;
                        st   <= div_retire ? S_IDLE : S_DONE;
                    end
                end
                S_DONE: if (div_retire) st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_valid <= 1'b0;
            bus.wb_addr  <= '0;
            bus.wb_data  <= '0;
        end else begin
            bus.wb_valid <= 1'b0;
            if (mfin_vld) begin
                bus.wb_valid <= 1'b1;
                bus.wb_addr  <= mfin_rd;
                bus.wb_data  <= mfin_data;
            end else if (div_wb) begin
                bus.wb_valid <= 1'b1;
                bus.wb_addr  <= drd;
                bus.wb_data  <= div_out;
            end
        end
    end

    // The register on wb_* is still in flight until the regfile latches it.
    logic [NREG-1:0] busy;
    always_comb begin
        busy = pipe_busy;
        if (st != S_IDLE) busy[drd] = 1'b1;
        if (bus.wb_valid) busy[bus.wb_addr] = 1'b1;
        busy[0] = 1'b0;
    end

    assign bus.stall_req = (bus.id_rs1_re & busy[bus.id_rs1_addr])
                         | (bus.id_rs2_re & busy[bus.id_rs2_addr])
                         | (bus.id_rd_we  & busy[bus.id_rd_addr]);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: op table plus hand-built contention,
// flush, reset and x0 sequences.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32), .REG_AW(5)) bus ();
    muldiv_unit #(.XLEN(32), .MULT_STAGES(3), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bus.issue_valid = v;
        bus.issue_op    = op;
        bus.issue_a     = a;
        bus.issue_b     = b;
        bus.issue_rd    = rd;
    endtask

    task automatic id_clear();
        bus.id_rs1_re = 0; bus.id_rs1_addr = '0;
        bus.id_rs2_re = 0; bus.id_rs2_addr = '0;
        bus.id_rd_we  = 0; bus.id_rd_addr  = '0;
    endtask

    initial begin
        int n;
        int seen;
        logic exp_v;
        logic [4:0] exp_a;
        logic [31:0] exp_d;

        vt[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 3};
        vt[1]  = '{3'd3, 32'h00000007, 32'hFFFFFFFD, 5'd6,  32'h00000006, 3};
        vt[2]  = '{3'd1, 32'h00000007, 32'hFFFFFFFD, 5'd4,  32'hFFFFFFFF, 3};
        vt[3]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 3};
        vt[4]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 3};
        vt[5]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 3};
        vt[6]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd7,  32'hFFFFFFFD, 33};
        vt[7]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd7,  32'hFFFFFFFF, 33};
        vt[8]  = '{3'd5, 32'd100,      32'h00000000, 5'd8,  32'hFFFFFFFF, 2};
        vt[9]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h00000000, 2};
        vt[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000, 2};
        vt[11] = '{3'd7, 32'd100,      32'd7,        5'd10, 32'h00000002, 33};
        vt[12] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 33};
        vt[13] = '{3'd6, 32'd5,        32'h00000000, 5'd11, 32'h00000005, 2};
        vt[14] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 33};
        vt[15] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd12, 32'h00000001, 33};
        vt[16] = '{3'd0, 32'h80000000, 32'h00000002, 5'd13, 32'h00000000, 3};

        // reset state
        rst = 1'b1;
        bus.issue_flush = 1'b0;
        drive(1'b0, 3'd4, '0, '0, '0);
        id_clear();
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_wb_addr", {27'd0, bus.wb_addr}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
        chk("rst_ready", {31'd0, bus.issue_ready}, 32'd1);

        // table: latency, address, data and 1-cycle pulse per op
        foreach (vt[i]) begin
            drive(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].rd);
            step();
            drive(1'b0, 3'd0, '0, '0, '0);
            n = 1;
            while (!bus.wb_valid && n < 60) begin
                step();
                n++;
            end
            chk($sformatf("v%0d_lat", i), n, vt[i].lat);
            chk($sformatf("v%0d_addr", i), {27'd0, bus.wb_addr}, {27'd0, vt[i].rd});
            chk($sformatf("v%0d_data", i), bus.wb_data, vt[i].exp);
            step();
            chk($sformatf("v%0d_pulse", i), {31'd0, bus.wb_valid}, 32'd0);
        end

        // back-to-back MULs to x1..x3 while ID reads x2
        bus.id_rs1_re = 1'b1; bus.id_rs1_addr = 5'd2;
        for (int k = 0; k <= 6; k++) begin
            if (k >= 1) begin
                exp_v = (k >= 3 && k <= 5);
                chk($sformatf("b2b_wbv%0d", k), {31'd0, bus.wb_valid}, {31'd0, exp_v});
                if (exp_v) begin
                    chk($sformatf("b2b_addr%0d", k), {27'd0, bus.wb_addr}, k - 2);
                    chk($sformatf("b2b_data%0d", k), bus.wb_data, (k - 2) * 10);
                end
                chk($sformatf("b2b_stall%0d", k), {31'd0, bus.stall_req},
                    {31'd0, (k >= 2 && k <= 4)});
            end
            if (k < 3) drive(1'b1, 3'd0, k + 1, 32'd10, 5'(k + 1));
            else       drive(1'b0, 3'd0, '0, '0, '0);
            step();
        end
        id_clear();

        // divider busy: second DIV held off, MUL slips in during CALC
        drive(1'b1, 3'd4, 32'd100, 32'd7, 5'd8);
        step();
        for (int k = 1; k <= 70; k++) begin
            exp_v = (k == 7 || k == 33 || k == 66);
            exp_a = (k == 7) ? 5'd10 : (k == 33) ? 5'd8 : 5'd9;
            exp_d = (k == 7) ? 32'd15 : (k == 33) ? 32'd14 : 32'd7;
            chk($sformatf("busy_wbv%0d", k), {31'd0, bus.wb_valid}, {31'd0, exp_v});
            if (exp_v) begin
                chk($sformatf("busy_addr%0d", k), {27'd0, bus.wb_addr}, {27'd0, exp_a});
                chk($sformatf("busy_data%0d", k), bus.wb_data, exp_d);
            end
            if (k == 4)       drive(1'b1, 3'd0, 32'd3, 32'd5, 5'd10);
            else if (k <= 33) drive(1'b1, 3'd4, 32'd50, 32'd7, 5'd9);
            else              drive(1'b0, 3'd0, '0, '0, '0);
            #1;
            if (k <= 33 && k != 4)
                chk($sformatf("busy_ready%0d", k), {31'd0, bus.issue_ready}, {31'd0, (k == 33)});
            step();
        end

        // divider completes under two consecutive mult writebacks
        bus.id_rs2_re = 1'b1; bus.id_rs2_addr = 5'd11;
        drive(1'b1, 3'd4, 32'd100, 32'd7, 5'd11);
        step();
        for (int k = 1; k <= 37; k++) begin
            exp_v = (k >= 33 && k <= 35);
            exp_a = (k == 33) ? 5'd12 : (k == 34) ? 5'd13 : 5'd11;
            exp_d = (k == 33) ? 32'd6 : (k == 34) ? 32'd20 : 32'd14;
            chk($sformatf("col_wbv%0d", k), {31'd0, bus.wb_valid}, {31'd0, exp_v});
            if (exp_v) begin
                chk($sformatf("col_addr%0d", k), {27'd0, bus.wb_addr}, {27'd0, exp_a});
                chk($sformatf("col_data%0d", k), bus.wb_data, exp_d);
            end
            chk($sformatf("col_stall%0d", k), {31'd0, bus.stall_req}, {31'd0, (k <= 35)});
            if (k == 30)      drive(1'b1, 3'd0, 32'd2, 32'd3, 5'd12);
            else if (k == 31) drive(1'b1, 3'd0, 32'd4, 32'd5, 5'd13);
            else              drive(1'b0, 3'd0, '0, '0, '0);
            step();
        end
        id_clear();

        // flushed issues leave no trace
        bus.issue_flush = 1'b1;
        drive(1'b1, 3'd0, 32'd3, 32'd3, 5'd7);
        step();
        drive(1'b1, 3'd4, 32'd9, 32'd3, 5'd7);
        step();
        bus.issue_flush = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
        chk("flush_ready", {31'd0, bus.issue_ready}, 32'd1);
        bus.id_rs1_re = 1'b1; bus.id_rs1_addr = 5'd7;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.wb_valid || bus.stall_req) seen++;
            step();
        end
        chk("flush_no_activity", seen, 0);
        id_clear();

        // reset mid-CALC
        drive(1'b1, 3'd4, 32'd1000, 32'd3, 5'd14);
        step();
        drive(1'b0, 3'd4, '0, '0, '0);
        for (int k = 0; k < 10; k++) step();
        bus.id_rs1_re = 1'b1; bus.id_rs1_addr = 5'd14;
        #1;
        chk("midcalc_stall", {31'd0, bus.stall_req}, 32'd1);
        chk("midcalc_ready", {31'd0, bus.issue_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mrst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("mrst_wb_addr", {27'd0, bus.wb_addr}, 32'd0);
        chk("mrst_wb_data", bus.wb_data, 32'd0);
        chk("mrst_stall", {31'd0, bus.stall_req}, 32'd0);
        chk("mrst_ready", {31'd0, bus.issue_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.wb_valid) seen++;
            step();
        end
        chk("mrst_no_wb", seen, 0);
        id_clear();

        // MUL to x0: computed but never tracked or written
        bus.id_rd_we = 1'b1; bus.id_rd_addr = 5'd0;
        bus.id_rs1_re = 1'b1; bus.id_rs1_addr = 5'd0;
        drive(1'b1, 3'd0, 32'd3, 32'd3, 5'd0);
        step();
        drive(1'b0, 3'd0, '0, '0, '0);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("x0_wbv%0d", k), {31'd0, bus.wb_valid}, 32'd0);
            chk($sformatf("x0_stall%0d", k), {31'd0, bus.stall_req}, 32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
